// File: rtl/raptor64_pkg.sv
// raptor64_pkg: shared widths and BTB sweep FSM encoding for the raptor64 core
package raptor64_pkg;
    localparam int BTB_IDX_W = 6;
    localparam int BTB_TAG_W = 16;
    localparam int ADDR_W    = 64;
    typedef enum logic {SWEEP, RUN} btb_state_t;
endpackage

// File: rtl/raptor64_btb_ram.sv
// raptor64_btb_ram: BTB storage, ENTRIES x {valid, tag, target}
//   rd_idx_i                          async read address
//   rd_valid_o/rd_tag_o/rd_target_o   entry contents at rd_idx_i
//   wr_en_i/wr_idx_i/wr_tag_i/wr_target_i  sync write, sets valid
//   clr_en_i/clr_idx_i                sync valid clear used by the sweep (wins over write)
module raptor64_btb_ram #(
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 16,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [ADDR_W-1:0] rd_target_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [ADDR_W-1:0] wr_target_i,
    input  logic              clr_en_i,
    input  logic [IDX_W-1:0]  clr_idx_i
);
    localparam int ENTRIES = 1 << IDX_W;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    always_ff @(posedge clk) begin
        if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
        else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            tgt_q[wr_idx_i] <= wr_target_i;
        end
    end
    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = tgt_q[rd_idx_i];
endmodule

// File: rtl/raptor64_branch_target_buffer.sv
// raptor64_branch_target_buffer: IF-stage branch target buffer with reset/flush sweep
//   clk, rst (async active-low), flush (1-cycle invalidate-all pulse)
//   pc, predict_taken -> btb_hit, btb_target (0 on miss), redirect, busy
//   advanceX, x_branch, takb, xpc, xtarget: EX-stage training on retiring taken branches
//   Define BTB_BYPASS_EN to forward a same-cycle matching update to the lookup.
module raptor64_branch_target_buffer #(
    parameter int IDX_W  = raptor64_pkg::BTB_IDX_W,
    parameter int TAG_W  = raptor64_pkg::BTB_TAG_W,
    parameter int ADDR_W = raptor64_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    input  logic              predict_taken,
    output logic              btb_hit,
    output logic [ADDR_W-1:0] btb_target,
    output logic              redirect,
    output logic              busy,
    input  logic              advanceX,
    input  logic              x_branch,
    input  logic              takb,
    input  logic [ADDR_W-1:0] xpc,
    input  logic [ADDR_W-1:0] xtarget
);
    import raptor64_pkg::*;
    btb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  pc_idx, x_idx;
    logic [TAG_W-1:0]  pc_tag, x_tag, rd_tag;
    logic [ADDR_W-1:0] rd_target;
    logic              rd_valid, upd, tbl_hit, fwd;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // A flush in either state restarts the sweep from entry 0; the count only
    // wraps on the last sweep cycle when handing over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SWEEP) begin
            if (flush) cnt_d = '0;
            else if (&cnt_q) begin
                state_d = RUN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
        end else if (flush) begin
            state_d = SWEEP;
            cnt_d   = '0;
        end
    end
    assign busy   = state_q == SWEEP;
    assign pc_idx = pc[IDX_W-1:0];
    assign pc_tag = pc[IDX_W+TAG_W-1:IDX_W];
    assign x_idx  = xpc[IDX_W-1:0];
    assign x_tag  = xpc[IDX_W+TAG_W-1:IDX_W];
    assign upd    = advanceX & x_branch & takb & !busy;
    raptor64_btb_ram #(.IDX_W(IDX_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) u_ram (
        .clk         (clk),
        .rd_idx_i    (pc_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .wr_en_i     (upd),
        .wr_idx_i    (x_idx),
        .wr_tag_i    (x_tag),
        .wr_target_i (xtarget),
        .clr_en_i    (busy),
        .clr_idx_i   (cnt_q)
    );
    assign tbl_hit = !busy & rd_valid & (rd_tag == pc_tag);
`ifdef BTB_BYPASS_EN
    assign fwd = upd & (x_idx == pc_idx) & (x_tag == pc_tag);
`else
    assign fwd = 1'b0;
`endif
    assign btb_hit    = tbl_hit | fwd;
    assign btb_target = fwd ? xtarget : tbl_hit ? rd_target : '0;
    assign redirect   = btb_hit & predict_taken & !busy;
endmodule

// File: tb/tb_raptor64_branch_target_buffer.sv
// tb_raptor64_branch_target_buffer: directed test with a behavioural BTB model checked every cycle
module tb_raptor64_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] pc = '0;
    logic        predict_taken = 1'b0;
    logic        btb_hit, redirect, busy;
    logic [63:0] btb_target;
    logic        advanceX = 1'b0;
    logic        x_branch = 1'b0;
    logic        takb = 1'b0;
    logic [63:0] xpc = '0;
    logic [63:0] xtarget = '0;
    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;
`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    raptor64_branch_target_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .pc(pc), .predict_taken(predict_taken),
        .btb_hit(btb_hit), .btb_target(btb_target), .redirect(redirect), .busy(busy),
        .advanceX(advanceX), .x_branch(x_branch), .takb(takb), .xpc(xpc), .xtarget(xtarget)
    );
    always #5 clk = ~clk;
    // model: busy for 'left' more edges; table indexed by pc[5:0], tagged by pc[21:6]
    int          left = 64;
    bit          mv [64];
    logic [15:0] mt [64];
    logic [63:0] mx [64];
    function automatic bit m_upd();
        return advanceX && x_branch && takb && left == 0;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            left <= 64;
            mv   <= '{default: 1'b0};
        end else if (left > 0) begin
            left <= flush ? 64 : left - 1;
        end else begin
            if (m_upd()) begin
                mv[xpc[5:0]] <= 1'b1;
                mt[xpc[5:0]] <= xpc[21:6];
                mx[xpc[5:0]] <= xtarget;
            end
            if (flush) begin
                left <= 64;
                mv   <= '{default: 1'b0};
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (armed) begin
            automatic bit          e_busy = left > 0;
            automatic bit          e_fwd = BYP && m_upd() && xpc[21:0] == pc[21:0];
            automatic bit          e_hit = !e_busy && (e_fwd || (mv[pc[5:0]] && mt[pc[5:0]] == pc[21:6]));
            automatic logic [63:0] e_tgt = !e_hit ? 64'h0 : e_fwd ? xtarget : mx[pc[5:0]];
            chk("model_busy", {63'b0, busy}, {63'b0, e_busy});
            chk("model_hit", {63'b0, btb_hit}, {63'b0, e_hit});
            chk("model_target", btb_target, e_tgt);
            chk("model_redirect", {63'b0, redirect}, {63'b0, e_hit && predict_taken});
        end
    end
    task automatic drv;
        @(posedge clk);
        #1;
    endtask
    task automatic smp;
        @(negedge clk);
        #1;
    endtask
    task automatic upd_set(input logic [63:0] a, input logic [63:0] t, input bit tk, input bit adv);
        advanceX = adv;
        x_branch = 1'b1;
        takb     = tk;
        xpc      = a;
        xtarget  = t;
    endtask
    task automatic upd_clr;
        advanceX = 1'b0;
        x_branch = 1'b0;
        takb     = 1'b0;
    endtask
    task automatic look(input string name, input logic [63:0] a, input bit h, input logic [63:0] t);
        pc = a;
        #1;
        chk({name, "_hit"}, {63'b0, btb_hit}, {63'b0, h});
        chk({name, "_tgt"}, btb_target, t);
    endtask
    task automatic sweep_len(input string name, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            drv;
            smp;
        end
        chk(name, 64'(n), 64'(exp));
    endtask
    task automatic train(input logic [63:0] a, input logic [63:0] t);
        drv;
        upd_set(a, t, 1'b1, 1'b1);
        drv;
        upd_clr;
    endtask
    initial begin
        repeat (3) drv;
        armed = 1'b1;
        smp;
        chk("reset_busy", {63'b0, busy}, 64'd1);
        chk("reset_hit", {63'b0, btb_hit}, 64'd0);
        chk("reset_redirect", {63'b0, redirect}, 64'd0);
        chk("reset_target", btb_target, 64'd0);
        rst = 1'b1;
        #1;
        sweep_len("reset_sweep_len", 64);
        // basic train and lookup
        train(64'h1234, 64'h8000);
        predict_taken = 1'b1;
        smp;
        look("t2", 64'h1234, 1'b1, 64'h8000);
        chk("t2_redirect_taken", {63'b0, redirect}, 64'd1);
        predict_taken = 1'b0;
        #1;
        chk("t2_redirect_nt", {63'b0, redirect}, 64'd0);
        // aliasing on index 5
        train(64'h0005, 64'hA0);
        smp;
        look("t3_a", 64'h0005, 1'b1, 64'hA0);
        look("t3_alias", 64'h10005, 1'b0, 64'h0);
        train(64'h10005, 64'hB0);
        smp;
        look("t3_old", 64'h0005, 1'b0, 64'h0);
        look("t3_new", 64'h10005, 1'b1, 64'hB0);
        // not-taken and stalled updates leave the entry alone
        drv;
        upd_set(64'h1234, 64'h7777, 1'b0, 1'b1);
        drv;
        upd_set(64'h1234, 64'h6666, 1'b1, 1'b0);
        drv;
        upd_clr;
        smp;
        look("t4", 64'h1234, 1'b1, 64'h8000);
        // same-cycle update and lookup
        drv;
        pc = 64'h1234;
        upd_set(64'h1234, 64'h9000, 1'b1, 1'b1);
        smp;
        chk("t5_same_hit", {63'b0, btb_hit}, 64'd1);
        chk("t5_same_tgt", btb_target, BYP ? 64'h9000 : 64'h8000);
        drv;
        upd_clr;
        smp;
        look("t5_next", 64'h1234, 1'b1, 64'h9000);
        // flush in RUN with a simultaneous update: written, then swept away
        drv;
        flush = 1'b1;
        upd_set(64'h2040, 64'h3000, 1'b1, 1'b1);
        smp;
        chk("t6_flush_busy0", {63'b0, busy}, 64'd0);
        chk("t6_flush_hit", {63'b0, btb_hit}, 64'd1);
        drv;
        flush = 1'b0;
        upd_clr;
        smp;
        chk("t6_busy_rise", {63'b0, busy}, 64'd1);
        chk("t6_busy_miss", {63'b0, btb_hit}, 64'd0);
        sweep_len("t6_flush_sweep_len", 64);
        look("t6_miss_1234", 64'h1234, 1'b0, 64'h0);
        look("t6_miss_2040", 64'h2040, 1'b0, 64'h0);
        look("t6_miss_10005", 64'h10005, 1'b0, 64'h0);
        // flush during sweep restarts the count
        train(64'h1234, 64'h5000);
        smp;
        look("t6_retrain", 64'h1234, 1'b1, 64'h5000);
        drv;
        flush = 1'b1;
        drv;
        flush = 1'b0;
        smp;
        repeat (4) begin
            drv;
            smp;
        end
        drv;
        flush = 1'b1;
        drv;
        flush = 1'b0;
        smp;
        sweep_len("t6_restart_sweep_len", 64);
        look("t6_restart_miss", 64'h1234, 1'b0, 64'h0);
        // reset at sweep cycle 10
        train(64'h1234, 64'h5000);
        drv;
        flush = 1'b1;
        drv;
        flush = 1'b0;
        smp;
        repeat (9) begin
            drv;
            smp;
        end
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", {63'b0, busy}, 64'd1);
        smp;
        rst = 1'b1;
        #1;
        sweep_len("t6_rst_sweep_len", 64);
        look("t6_rst_miss", 64'h1234, 1'b0, 64'h0);
        drv;
        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
